// File: rtl/if_bus_if_if.sv
// rtl/if_bus_if_if.sv - arbitrated instruction-fetch memory bus bundle
interface if_bus_if_if #(
    parameter int DAT_WIDTH = 32,
    parameter int ADD_WIDTH = 30
);
    logic                 bus_req_o;
    logic                 bus_grant_i;
    logic [ADD_WIDTH-1:0] bus_addr_o;
    logic                 bus_as_o;
    logic [DAT_WIDTH-1:0] bus_rd_data_i;
    logic                 bus_rdy_i;
    logic                 bus_err_o;

    modport master (
        output bus_req_o,
        output bus_addr_o,
        output bus_as_o,
        output bus_err_o,
        input  bus_grant_i,
        input  bus_rd_data_i,
        input  bus_rdy_i
    );

    modport slave (
        input  bus_req_o,
        input  bus_addr_o,
        input  bus_as_o,
        input  bus_err_o,
        output bus_grant_i,
        output bus_rd_data_i,
        output bus_rdy_i
    );
endinterface

// File: rtl/if_bus_if.sv
// rtl/if_bus_if.sv - instruction-fetch bus master (IDLE/REQ/ACCESS)
// Optional ACCESS watchdog enabled by defining IF_BUS_TIMEOUT_EN.
module if_bus_if #(
    parameter int                   DAT_WIDTH   = 32,
    parameter int                   ADD_WIDTH   = 30,
    parameter int                   TIMEOUT_CYC = 16,
    parameter logic [DAT_WIDTH-1:0] ISA_NOP     = 'h13
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 fetch_req_i,
    input  logic [ADD_WIDTH-1:0] pc_i,
    input  logic                 flush_i,
    output logic [DAT_WIDTH-1:0] instru_o,
    output logic                 busy_o,
    if_bus_if_if.master          bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_bus_req;
    logic                 r_bus_as;
    logic [ADD_WIDTH-1:0] r_bus_addr;
    logic                 r_abort;
    logic                 w_complete;

`ifdef IF_BUS_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_bus_err;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_bus_req  <= 1'b0;
            r_bus_as   <= 1'b0;
            r_bus_addr <= '0;
            r_abort    <= 1'b0;
`ifdef IF_BUS_TIMEOUT_EN
            r_tmo_cnt  <= '0;
            r_bus_err  <= 1'b0;
`endif
        end else begin
            r_bus_as  <= 1'b0;
`ifdef IF_BUS_TIMEOUT_EN
            r_bus_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    r_bus_req <= 1'b0;
                    if (fetch_req_i) begin
                        r_state   <= S_REQ;
                        r_bus_req <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (!fetch_req_i) begin
                        r_state   <= S_IDLE;
                        r_bus_req <= 1'b0;
                    end else if (bus.bus_grant_i) begin
                        r_state    <= S_ACCESS;
                        r_bus_addr <= pc_i;
                        r_bus_as   <= 1'b1;
`ifdef IF_BUS_TIMEOUT_EN
                        r_tmo_cnt  <= '0;
`endif
                    end
                end
                S_ACCESS: begin
                    if (bus.bus_rdy_i) begin
                        r_abort   <= 1'b0;
                        r_state   <= fetch_req_i ? S_REQ : S_IDLE;
                        r_bus_req <= fetch_req_i;
                    end else begin
                        // A flush during a pending access cannot cancel it on the bus; drop its data later.
                        if (flush_i) begin
                            r_abort <= 1'b1;
                        end
`ifdef IF_BUS_TIMEOUT_EN
                        if (r_tmo_cnt == TMO_LAST) begin
                            r_bus_err <= 1'b1;
                            r_abort   <= 1'b0;
                            r_state   <= S_IDLE;
                            r_bus_req <= 1'b0;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_bus_req <= 1'b0;
                end
            endcase
        end
    end

    assign w_complete = !rst_i && (r_state == S_ACCESS) && bus.bus_rdy_i
                        && !r_abort && !flush_i;
    assign instru_o   = w_complete ? bus.bus_rd_data_i : ISA_NOP;
    assign busy_o     = !rst_i && !w_complete && fetch_req_i && !flush_i;

    assign bus.bus_req_o  = r_bus_req;
    assign bus.bus_as_o   = r_bus_as;
    assign bus.bus_addr_o = r_bus_addr;
`ifdef IF_BUS_TIMEOUT_EN
    assign bus.bus_err_o  = r_bus_err;
`else
    assign bus.bus_err_o  = (TIMEOUT_CYC < 0);
`endif
endmodule

// File: tb/tb_if_bus_if.sv
// tb/tb_if_bus_if.sv - scoreboard bench for if_bus_if
`timescale 1ns/1ps
module tb_if_bus_if;
    localparam int             DW  = 32;
    localparam int             AW  = 30;
    localparam logic [DW-1:0]  NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst, fetch_req, flush, grant, rdy;
    logic [AW-1:0] pc;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] instru;
    logic          busy;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_v;
    int            vecs = 0;
    int            errs = 0;

    always #5 clk = ~clk;

    if_bus_if_if #(.DAT_WIDTH(DW), .ADD_WIDTH(AW)) bus_if ();
    assign bus_if.bus_grant_i   = grant;
    assign bus_if.bus_rd_data_i = rd_data;
    assign bus_if.bus_rdy_i     = rdy;

    if_bus_if #(.DAT_WIDTH(DW), .ADD_WIDTH(AW), .TIMEOUT_CYC(16), .ISA_NOP(NOP)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .fetch_req_i (fetch_req),
        .pc_i        (pc),
        .flush_i     (flush),
        .instru_o    (instru),
        .busy_o      (busy),
        .bus         (bus_if)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic go_idle();
        fetch_req = 1'b0;
        tick();
        rdy = 1'b0;
        flush = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_req = 1'b1; flush = 1'b0; grant = 1'b1; rdy = 1'b1;
        pc = 30'h3ff; rd_data = 32'hffff_ffff;
        tick(); tick();
        vecs++; if (bus_if.bus_req_o !== 1'b0) begin errs++; $display("FAIL reset_req got=%0h want=0", bus_if.bus_req_o); end
        vecs++; if (bus_if.bus_as_o !== 1'b0) begin errs++; $display("FAIL reset_as got=%0h want=0", bus_if.bus_as_o); end
        vecs++; if (bus_if.bus_addr_o !== 30'h0) begin errs++; $display("FAIL reset_addr got=%0h want=0", bus_if.bus_addr_o); end
        vecs++; if (bus_if.bus_err_o !== 1'b0) begin errs++; $display("FAIL reset_err got=%0h want=0", bus_if.bus_err_o); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%0h want=0", busy); end
        vecs++; if (instru !== NOP) begin errs++; $display("FAIL reset_instru got=%0h want=%0h", instru, NOP); end
        vecs++; if (dut.r_state !== 2'd0) begin errs++; $display("FAIL reset_state got=%0d want=0", dut.r_state); end
    endtask

    task automatic test_basic();
        rst = 1'b0; fetch_req = 1'b1; pc = 30'h10; grant = 1'b1; rdy = 1'b0; rd_data = 32'h1234_5678;
        settle();
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL basic_busy_c0 got=%0h want=1", busy); end
        tick();
        vecs++; if (bus_if.bus_req_o !== 1'b1) begin errs++; $display("FAIL basic_req_c1 got=%0h want=1", bus_if.bus_req_o); end
        vecs++; if (bus_if.bus_as_o !== 1'b0) begin errs++; $display("FAIL basic_as_c1 got=%0h want=0", bus_if.bus_as_o); end
        tick();
        rdy = 1'b1; exp_q.push_back(32'h1234_5678);
        settle();
        vecs++; if (bus_if.bus_as_o !== 1'b1) begin errs++; $display("FAIL basic_as_c2 got=%0h want=1", bus_if.bus_as_o); end
        vecs++; if (bus_if.bus_addr_o !== 30'h10) begin errs++; $display("FAIL basic_addr_c2 got=%0h want=10", bus_if.bus_addr_o); end
        vecs++;
        if (exp_q.size() == 0) begin errs++; $display("FAIL basic_sb got=empty want=entry"); end
        else begin
            exp_v = exp_q.pop_front();
            if (instru !== exp_v) begin errs++; $display("FAIL basic_instru got=%0h want=%0h", instru, exp_v); end
        end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL basic_busy_c2 got=%0h want=0", busy); end
        tick();
        rdy = 1'b0;
        settle();
        vecs++; if (dut.r_state !== 2'd1) begin errs++; $display("FAIL basic_state_c3 got=%0d want=1", dut.r_state); end
        vecs++; if (bus_if.bus_req_o !== 1'b1) begin errs++; $display("FAIL basic_req_c3 got=%0h want=1", bus_if.bus_req_o); end
        fetch_req = 1'b0;
        tick();
        vecs++; if (bus_if.bus_req_o !== 1'b0) begin errs++; $display("FAIL basic_req_idle got=%0h want=0", bus_if.bus_req_o); end
    endtask

    task automatic test_grant_wait();
        fetch_req = 1'b1; grant = 1'b0; pc = 30'h20;
        tick();
        for (int i = 0; i < 3; i++) begin
            pc = 30'h20 + 30'(i);
            settle();
            vecs++; if (bus_if.bus_req_o !== 1'b1 || busy !== 1'b1 || bus_if.bus_as_o !== 1'b0) begin
                errs++; $display("FAIL grant_wait_%0d got req=%0h busy=%0h as=%0h want req=1 busy=1 as=0", i, bus_if.bus_req_o, busy, bus_if.bus_as_o);
            end
            tick();
        end
        grant = 1'b1; pc = 30'h33;
        tick();
        grant = 1'b0; pc = 30'h3a; rdy = 1'b1; rd_data = 32'ha5a5_0001; exp_q.push_back(32'ha5a5_0001);
        settle();
        vecs++; if (bus_if.bus_as_o !== 1'b1 || bus_if.bus_addr_o !== 30'h33) begin
            errs++; $display("FAIL grant_access got as=%0h addr=%0h want as=1 addr=33", bus_if.bus_as_o, bus_if.bus_addr_o);
        end
        vecs++;
        if (exp_q.size() == 0) begin errs++; $display("FAIL grant_sb got=empty want=entry"); end
        else begin
            exp_v = exp_q.pop_front();
            if (instru !== exp_v) begin errs++; $display("FAIL grant_instru got=%0h want=%0h", instru, exp_v); end
        end
        go_idle();
    endtask

    task automatic test_wait_states();
        fetch_req = 1'b1; grant = 1'b1; pc = 30'h50; rdy = 1'b0; rd_data = 32'hdead_beef;
        tick(); tick();
        pc = 30'h55;
        for (int i = 0; i < 4; i++) begin
            settle();
            vecs++; if (bus_if.bus_as_o !== (i == 0) || busy !== 1'b1 || instru !== NOP || bus_if.bus_addr_o !== 30'h50) begin
                errs++; $display("FAIL wait_%0d got as=%0h busy=%0h instru=%0h addr=%0h want as=%0h busy=1 instru=%0h addr=50",
                                 i, bus_if.bus_as_o, busy, instru, bus_if.bus_addr_o, (i == 0), NOP);
            end
            tick();
        end
        rdy = 1'b1; exp_q.push_back(32'hdead_beef);
        settle();
        vecs++;
        if (exp_q.size() == 0) begin errs++; $display("FAIL wait_sb got=empty want=entry"); end
        else begin
            exp_v = exp_q.pop_front();
            if (instru !== exp_v || busy !== 1'b0) begin errs++; $display("FAIL wait_done got instru=%0h busy=%0h want instru=%0h busy=0", instru, busy, exp_v); end
        end
        go_idle();
    endtask

    task automatic test_back_to_back();
        fetch_req = 1'b1; grant = 1'b1; rdy = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            pc = 30'h100 + 30'(k);
            settle();
            vecs++; if (busy !== 1'b1 || bus_if.bus_req_o !== 1'b1) begin
                errs++; $display("FAIL b2b_req_%0d got busy=%0h req=%0h want busy=1 req=1", k, busy, bus_if.bus_req_o);
            end
            tick();
            rdy = 1'b1; rd_data = 32'hc0de_0000 + k; exp_q.push_back(32'hc0de_0000 + k);
            settle();
            vecs++;
            if (exp_q.size() == 0) begin errs++; $display("FAIL b2b_sb_%0d got=empty want=entry", k); end
            else begin
                exp_v = exp_q.pop_front();
                if (instru !== exp_v || busy !== 1'b0 || bus_if.bus_addr_o !== 30'h100 + 30'(k)) begin
                    errs++; $display("FAIL b2b_data_%0d got instru=%0h busy=%0h addr=%0h want instru=%0h busy=0 addr=%0h",
                                     k, instru, busy, bus_if.bus_addr_o, exp_v, 30'h100 + 30'(k));
                end
            end
            if (k < 2) begin
                tick();
                rdy = 1'b0;
            end
        end
        go_idle();
    endtask

    task automatic test_flush();
        fetch_req = 1'b1; grant = 1'b1; pc = 30'h30; rdy = 1'b0; flush = 1'b0;
        tick(); tick(); tick();
        flush = 1'b1; pc = 30'h40;
        settle();
        vecs++; if (busy !== 1'b0 || instru !== NOP) begin errs++; $display("FAIL flush_busy got busy=%0h instru=%0h want busy=0 instru=%0h", busy, instru, NOP); end
        tick();
        flush = 1'b0; rdy = 1'b1; rd_data = 32'h1111_2222; exp_q.push_back(NOP);
        settle();
        vecs++;
        if (exp_q.size() == 0) begin errs++; $display("FAIL flush_sb got=empty want=entry"); end
        else begin
            exp_v = exp_q.pop_front();
            if (instru !== exp_v || busy !== 1'b1) begin errs++; $display("FAIL flush_drop got instru=%0h busy=%0h want instru=%0h busy=1", instru, busy, exp_v); end
        end
        tick();
        rdy = 1'b0;
        tick();
        flush = 1'b1; rdy = 1'b1; rd_data = 32'h2222_3333; exp_q.push_back(NOP);
        settle();
        vecs++; if (bus_if.bus_addr_o !== 30'h40 || bus_if.bus_as_o !== 1'b1) begin
            errs++; $display("FAIL flush_redirect got addr=%0h as=%0h want addr=40 as=1", bus_if.bus_addr_o, bus_if.bus_as_o);
        end
        vecs++;
        if (exp_q.size() == 0) begin errs++; $display("FAIL flush_rdy_sb got=empty want=entry"); end
        else begin
            exp_v = exp_q.pop_front();
            if (instru !== exp_v || busy !== 1'b0) begin errs++; $display("FAIL flush_rdy got instru=%0h busy=%0h want instru=%0h busy=0", instru, busy, exp_v); end
        end
        tick();
        flush = 1'b0; rdy = 1'b0;
        tick();
        rdy = 1'b1; rd_data = 32'h4444_5555; exp_q.push_back(32'h4444_5555);
        settle();
        vecs++;
        if (exp_q.size() == 0) begin errs++; $display("FAIL flush_after_sb got=empty want=entry"); end
        else begin
            exp_v = exp_q.pop_front();
            if (instru !== exp_v || busy !== 1'b0) begin errs++; $display("FAIL flush_after got instru=%0h busy=%0h want instru=%0h busy=0", instru, busy, exp_v); end
        end
        go_idle();
    endtask

    task automatic test_reset_mid();
        fetch_req = 1'b1; grant = 1'b1; pc = 30'h70; rdy = 1'b0;
        tick(); tick();
        vecs++; if (bus_if.bus_addr_o !== 30'h70) begin errs++; $display("FAIL rstmid_addr got=%0h want=70", bus_if.bus_addr_o); end
        rst = 1'b1;
        tick();
        rst = 1'b0; fetch_req = 1'b0; rdy = 1'b1; rd_data = 32'h0000_0bad;
        settle();
        vecs++; if (bus_if.bus_req_o !== 1'b0 || bus_if.bus_as_o !== 1'b0 || bus_if.bus_addr_o !== 30'h0) begin
            errs++; $display("FAIL rstmid_bus got req=%0h as=%0h addr=%0h want 0 0 0", bus_if.bus_req_o, bus_if.bus_as_o, bus_if.bus_addr_o);
        end
        vecs++; if (instru !== NOP || busy !== 1'b0 || dut.r_state !== 2'd0) begin
            errs++; $display("FAIL rstmid_late_rdy got instru=%0h busy=%0h state=%0d want instru=%0h busy=0 state=0", instru, busy, dut.r_state, NOP);
        end
        tick();
        rdy = 1'b0;
        settle();
        vecs++; if (bus_if.bus_req_o !== 1'b0 || bus_if.bus_err_o !== 1'b0) begin
            errs++; $display("FAIL rstmid_idle got req=%0h err=%0h want req=0 err=0", bus_if.bus_req_o, bus_if.bus_err_o);
        end
    endtask

`ifdef IF_BUS_TIMEOUT_EN
    task automatic test_timeout();
        fetch_req = 1'b1; grant = 1'b1; pc = 30'h90; rdy = 1'b0;
        tick(); tick();
        for (int i = 0; i < 16; i++) begin
            settle();
            vecs++; if (bus_if.bus_err_o !== 1'b0 || bus_if.bus_req_o !== 1'b1) begin
                errs++; $display("FAIL tmo_wait_%0d got err=%0h req=%0h want err=0 req=1", i, bus_if.bus_err_o, bus_if.bus_req_o);
            end
            tick();
        end
        fetch_req = 1'b0;
        settle();
        vecs++; if (bus_if.bus_err_o !== 1'b1 || bus_if.bus_req_o !== 1'b0 || dut.r_state !== 2'd0) begin
            errs++; $display("FAIL tmo_fire got err=%0h req=%0h state=%0d want err=1 req=0 state=0", bus_if.bus_err_o, bus_if.bus_req_o, dut.r_state);
        end
        tick();
        vecs++; if (bus_if.bus_err_o !== 1'b0) begin errs++; $display("FAIL tmo_pulse got=%0h want=0", bus_if.bus_err_o); end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_grant_wait();
        test_wait_states();
        test_back_to_back();
        test_flush();
        test_reset_mid();
`ifdef IF_BUS_TIMEOUT_EN
        test_timeout();
`endif
        vecs++; if (exp_q.size() != 0) begin errs++; $display("FAIL sb_leftover got=%0d want=0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/if_bus_if.md
Name: if_bus_if

Overview:
- Instruction-fetch bus master that sits directly upstream of the fetch pipeline register.
- Takes the pipeline's fetch PC and issues word reads on the shared arbitrated memory bus (request/grant, address strobe, ready).
- Returns the fetched instruction word on a combinational path.
- Drives the pipeline stall (busy) while a fetch is outstanding.

Parameters:
- DAT_WIDTH, 32, instruction/bus data width.
- ADD_WIDTH, 30, word address width (PC is a word address).
- TIMEOUT_CYC, 16, watchdog limit in ACCESS cycles (used only with IF_BUS_TIMEOUT_EN).

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- fetch_req_i  in  1  pipeline wants an instruction this cycle.
- pc_i  in  ADD_WIDTH  word address to fetch.
- flush_i  in  1  pipeline redirect; any in-flight data must be discarded.
- instru_o  out  DAT_WIDTH  fetched instruction; ISA_NOP when not completing.
- busy_o  out  1  stall request to the fetch pipeline register.
- bus_req_o  out  1  bus request to the arbiter.
- bus_grant_i  in  1  arbiter grant.
- bus_addr_o  out  ADD_WIDTH  registered read address.
- bus_as_o  out  1  address strobe, one-cycle pulse.
- bus_rd_data_i  in  DAT_WIDTH  read data.
- bus_rdy_i  in  1  read data valid / access complete.
- bus_err_o  out  1  timeout error pulse (tied 0 without the optional feature).

Behaviour:
- States: IDLE, REQ, ACCESS; 2-bit encoding. Internal abort flag (discard pending).
- Reset, synchronous while rst_i=1: state=IDLE, bus_req_o=0, bus_as_o=0, bus_addr_o=0, abort=0, bus_err_o=0. Combinational outputs forced: busy_o=0, instru_o=ISA_NOP.
- IDLE:
  - bus_req_o=0.
  - fetch_req_i=1 -> REQ next cycle; bus_req_o registered to 1.
- REQ:
  - bus_req_o=1.
  - bus_grant_i=1 and fetch_req_i=1 -> ACCESS; latch bus_addr_o<=pc_i; bus_as_o<=1 for the first ACCESS cycle only.
  - fetch_req_i=0 -> IDLE; bus_req_o<=0.
- ACCESS:
  - bus_req_o held at 1; bus_addr_o held stable until completion.
  - Completes on bus_rdy_i=1 in any ACCESS cycle, including the first. Wait states are unbounded (without the optional feature).
  - On completion: next state=REQ if fetch_req_i=1 (bus stays held, no re-arbitration gap beyond grant), else IDLE; abort<=0.
- Completion output, combinational:
  - When ACCESS & bus_rdy_i & !abort & !flush_i: instru_o=bus_rd_data_i and busy_o=0.
  - Otherwise: instru_o=ISA_NOP and busy_o=fetch_req_i & !flush_i.
- Flush:
  - flush_i=1 forces busy_o=0 that cycle so the pipeline register accepts the redirect.
  - If in ACCESS without rdy, set abort=1; the access runs to bus_rdy_i and its data is dropped (NOP, busy_o stays high if fetch_req_i).
  - Flush coinciding with rdy: data dropped, no abort set.
  - Flush in IDLE/REQ: no state effect; the next ACCESS latches the redirected pc_i.
- Grant lost: bus_grant_i dropping in REQ keeps REQ. Grant is not sampled during ACCESS; the arbiter must not revoke mid-access.
- Timing:
  - Best case is 2 cycles per instruction back-to-back (REQ + ACCESS with rdy).
  - First fetch from IDLE takes 3 cycles.

Optional Feature:
- IF_BUS_TIMEOUT_EN defined:
  - Counter cleared on ACCESS entry, incremented each ACCESS cycle without rdy.
  - Reaching TIMEOUT_CYC -> bus_err_o=1 for one cycle, access abandoned, instru_o=ISA_NOP, abort cleared, state -> IDLE (bus_req_o<=0).
  - The pipeline re-requests normally afterwards.
- Undefined: no counter; bus_err_o constant 0; ACCESS waits indefinitely.

Test Plan:
- Reset, then fetch_req_i=1, pc_i=0x10, grant=1, rdy in first ACCESS cycle, data=0x12345678:
  - bus_req_o=1 at cycle1; bus_as_o=1 and bus_addr_o=0x10 at cycle2.
  - instru_o=0x12345678 and busy_o=0 at cycle2.
  - State returns to REQ at cycle3.
- Grant withheld 3 cycles:
  - bus_req_o high and busy_o=1 throughout.
  - ACCESS entered the cycle after grant.
  - Bus address latched from pc_i at the grant cycle.
- rdy delayed 4 wait states:
  - bus_as_o high exactly 1 cycle; busy_o=1 for 4 ACCESS cycles.
  - instru_o=ISA_NOP until the rdy cycle.
- flush_i in 2nd ACCESS wait cycle with pc_i changing to 0x40:
  - busy_o=0 that cycle.
  - The old access's rdy data is returned as ISA_NOP with busy_o=1.
  - Next ACCESS shows bus_addr_o=0x40.
- rst_i asserted mid-ACCESS:
  - Next cycle state IDLE; bus_req_o=0, bus_as_o=0, bus_addr_o=0.
  - A late bus_rdy_i is ignored.
- With IF_BUS_TIMEOUT_EN, TIMEOUT_CYC=16, rdy never asserted:
  - bus_err_o pulses for 1 cycle after 16 ACCESS cycles.
  - State then IDLE and bus_req_o=0.
